// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, reset/bubble defaults
// and an address-alignment helper.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_KILL  = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response channel between fetch and memory.
interface if_fetch_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;

   modport master (output im_req, output im_addr, input im_ack, input im_rdata);
   modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched instruction and its PC while
// decode is stalled.
module if_skid_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc
);

   logic        valid_r;
   logic [31:0] instr_r;
   logic [31:0] pc_r;

   // Entry storage; clear wins over load so a flush always empties the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         instr_r <= 32'd0;
         pc_r    <= 32'd0;
      end else if (clear) begin
         valid_r <= 1'b0;
      end else if (load) begin
         valid_r <= 1'b1;
         instr_r <= load_instr;
         pc_r    <= load_pc;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign valid = valid_r;
   assign instr = instr_r;
   assign pc    = pc_r;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: single outstanding memory request, one-entry skid
// for decode stalls, and flush/redirect handling that never abandons a request.
module if_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   if_fetch_if.master  imem,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic        isinstruct_IF
);

   fetch_state_e state_r;
   logic [31:0]  pc_r;
   logic [31:0]  kill_addr_r;
   logic [31:0]  instr_r;
   logic [31:0]  pc_out_r;
   logic         valid_r;

   logic         skid_load_s;
   logic         skid_clr_s;
   logic         skid_valid_s;
   logic [31:0]  skid_instr_s;
   logic [31:0]  skid_pc_s;
   logic [31:0]  redir_pc_s;

   assign redir_pc_s = word_align(redirect_pc);

   // KILL keeps presenting the abandoned address until its response drains.
   assign imem.im_req  = (state_r != ST_HOLD) && !rst;
   assign imem.im_addr = (state_r == ST_KILL) ? kill_addr_r : pc_r;

   // Skid control: capture on an accepted response under stall, drop on flush or drain.
   always_comb begin
      skid_load_s = 1'b0;
      skid_clr_s  = 1'b0;
      case (state_r)
         ST_FETCH: begin
            if (redirect) begin
               skid_clr_s = 1'b1;
            end else if (imem.im_ack && stall) begin
               skid_load_s = 1'b1;
            end else begin
               skid_load_s = 1'b0;
            end
         end
         ST_HOLD: begin
            if (redirect || !stall) begin
               skid_clr_s = 1'b1;
            end else begin
               skid_clr_s = 1'b0;
            end
         end
         ST_KILL: skid_clr_s = 1'b0;
         default: skid_clr_s = 1'b1;
      endcase
   end

   if_skid_buf u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (skid_load_s),
      .clear      (skid_clr_s),
      .load_instr (imem.im_rdata),
      .load_pc    (pc_r),
      .valid      (skid_valid_s),
      .instr      (skid_instr_s),
      .pc         (skid_pc_s)
   );

   // Fetch FSM with registered decode-side outputs; redirect outranks stall and ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_FETCH;
         pc_r        <= word_align(RESET_PC);
         kill_addr_r <= 32'd0;
         instr_r     <= NOP_INSTR;
         pc_out_r    <= 32'd0;
         valid_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (redirect) begin
                  instr_r  <= NOP_INSTR;
                  pc_out_r <= 32'd0;
                  valid_r  <= 1'b0;
                  pc_r     <= redir_pc_s;
                  if (!imem.im_ack) begin
                     kill_addr_r <= pc_r;
                     state_r     <= ST_KILL;
                  end
               end else if (imem.im_ack) begin
                  pc_r <= pc_r + 32'd4;
                  if (stall) begin
                     state_r <= ST_HOLD;
                  end else begin
                     instr_r  <= imem.im_rdata;
                     pc_out_r <= pc_r;
                     valid_r  <= 1'b1;
                  end
               end else if (!stall) begin
                  instr_r  <= NOP_INSTR;
                  pc_out_r <= 32'd0;
                  valid_r  <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  instr_r  <= NOP_INSTR;
                  pc_out_r <= 32'd0;
                  valid_r  <= 1'b0;
                  pc_r     <= redir_pc_s;
                  state_r  <= ST_FETCH;
               end else if (!stall) begin
                  instr_r  <= skid_instr_s;
                  pc_out_r <= skid_pc_s;
                  valid_r  <= skid_valid_s;
                  state_r  <= ST_FETCH;
               end
            end
            ST_KILL: begin
               if (redirect) begin
                  pc_r <= redir_pc_s;
               end
               if (redirect || !stall) begin
                  instr_r  <= NOP_INSTR;
                  pc_out_r <= 32'd0;
                  valid_r  <= 1'b0;
               end
               if (imem.im_ack) begin
                  state_r <= ST_FETCH;
               end
            end
            default: begin
               state_r  <= ST_FETCH;
               instr_r  <= NOP_INSTR;
               pc_out_r <= 32'd0;
               valid_r  <= 1'b0;
            end
         endcase
      end
   end

   assign instr         = instr_r;
   assign pc_out        = pc_out_r;
   assign isinstruct_IF = valid_r;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: latency-programmable memory model plus a
// scoreboard of expected retired instructions.
module tb_if_fetch;
   import cpu_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic        isinstruct_IF;

   int tests_run = 0;
   int fails = 0;
   int mem_lat = 1000;
   int mem_cnt = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;
   exp_t exp_q[$];

   if_fetch_if imem ();

   if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (imem),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .instr         (instr),
      .pc_out        (pc_out),
      .isinstruct_IF (isinstruct_IF)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA500_0000 ^ a;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.instr = mem_word(pc);
      e.pc    = pc;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input int lat);
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      mem_lat = lat;
      step(); step();
      exp_q.delete();
      rst = 1'b0;
   endtask

   // Memory model: acks after mem_lat wait cycles, checks address stability.
   logic        prev_req = 1'b0, prev_ack = 1'b0;
   logic [31:0] prev_addr = 32'd0;
   initial begin
      imem.im_ack = 1'b0;
      imem.im_rdata = 32'd0;
      forever begin
         @(posedge clk); #2;
         if (rst) begin
            imem.im_ack = 1'b0; mem_cnt = 0; prev_req = 1'b0; prev_ack = 1'b0;
         end else begin
            if (imem.im_req) begin
               if (prev_req && !prev_ack) begin
                  tests_run++;
                  if (imem.im_addr !== prev_addr) begin
                     fails++;
                     $display("FAIL addr_stable: got %h required %h", imem.im_addr, prev_addr);
                  end
               end
               tests_run++;
               if (imem.im_addr[1:0] !== 2'b00) begin
                  fails++;
                  $display("FAIL addr_align: got %h", imem.im_addr);
               end
               if (mem_cnt >= mem_lat) begin
                  imem.im_ack = 1'b1; imem.im_rdata = mem_word(imem.im_addr); mem_cnt = 0;
               end else begin
                  imem.im_ack = 1'b0; imem.im_rdata = 32'hDEAD_BEEF; mem_cnt++;
               end
            end else begin
               imem.im_ack = 1'b0; mem_cnt = 0;
            end
            prev_req = imem.im_req; prev_ack = imem.im_ack; prev_addr = imem.im_addr;
         end
      end
   end

   // Scoreboard consumer: decode accepts a valid instruction in any cycle without stall.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && isinstruct_IF === 1'b1 && stall === 1'b0) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid: instr %h pc %h, none required", instr, pc_out);
         end else begin
            e = exp_q.pop_front();
            if (instr !== e.instr || pc_out !== e.pc) begin
               fails++;
               $display("FAIL retire: got instr %h pc %h required instr %h pc %h",
                        instr, pc_out, e.instr, e.pc);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0500;
      step(); step();
      tests_run++;
      if (imem.im_req !== 1'b0 || instr !== NOP || pc_out !== 32'd0 ||
          isinstruct_IF !== 1'b0 || dut.state_r !== ST_FETCH) begin
         fails++;
         $display("FAIL reset_state: req %b instr %h pc %h valid %b", imem.im_req, instr, pc_out, isinstruct_IF);
      end
      rst = 1'b0; stall = 1'b0; redirect = 1'b0;
      #1;
      tests_run++;
      if (imem.im_req !== 1'b1 || imem.im_addr !== 32'd0) begin
         fails++;
         $display("FAIL reset_first_req: req %b addr %h required 1 00000000", imem.im_req, imem.im_addr);
      end
   endtask

   task automatic test_sequential();
      do_reset(0);
      for (int i = 0; i < 8; i++) push_exp(32'(4 * i));
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (imem.im_addr !== 32'(4 * i)) begin
            fails++;
            $display("FAIL seq_addr[%0d]: got %h required %h", i, imem.im_addr, 32'(4 * i));
         end
         step();
      end
      mem_lat = 1000; step(); step();
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL seq_drain: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_latency();
      do_reset(3);
      for (int i = 0; i < 4; i++) push_exp(32'(4 * i));
      for (int c = 0; c < 16; c++) begin
         tests_run++;
         if (imem.im_addr !== 32'(4 * (c / 4))) begin
            fails++;
            $display("FAIL lat_addr[%0d]: got %h required %h", c, imem.im_addr, 32'(4 * (c / 4)));
         end
         if (c % 4 != 0) begin
            tests_run++;
            if (instr !== NOP || isinstruct_IF !== 1'b0 || pc_out !== 32'd0) begin
               fails++;
               $display("FAIL lat_bubble[%0d]: got %h/%b required %h/0", c, instr, isinstruct_IF, NOP);
            end
         end
         step();
      end
      mem_lat = 1000; step(); step();
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL lat_drain: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_stall();
      do_reset(0);
      for (int i = 0; i < 6; i++) push_exp(32'(4 * i));
      for (int c = 0; c < 4; c++) step();
      tests_run++;
      if (imem.im_addr !== 32'h10) begin fails++; $display("FAIL stall_pre_addr: got %h required 00000010", imem.im_addr); end
      stall = 1'b1;
      step();
      for (int c = 5; c < 8; c++) begin
         tests_run++;
         if (imem.im_req !== 1'b0 || dut.state_r !== ST_HOLD || instr !== mem_word(32'hC) || isinstruct_IF !== 1'b1) begin
            fails++;
            $display("FAIL stall_hold[%0d]: req %b instr %h valid %b required 0 %h 1", c, imem.im_req, instr, isinstruct_IF, mem_word(32'hC));
         end
         step();
      end
      stall = 1'b0;
      step();
      tests_run++;
      if (instr !== mem_word(32'h10) || pc_out !== 32'h10 || isinstruct_IF !== 1'b1 ||
          imem.im_req !== 1'b1 || imem.im_addr !== 32'h14) begin
         fails++;
         $display("FAIL stall_release: instr %h pc %h addr %h required %h 00000010 00000014", instr, pc_out, imem.im_addr, mem_word(32'h10));
      end
      step();
      mem_lat = 1000; step(); step();
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL stall_drain: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_redirect_pending();
      do_reset(0);
      for (int i = 0; i < 16; i++) push_exp(32'(4 * i));
      push_exp(32'h200);
      for (int c = 0; c < 16; c++) step();
      tests_run++;
      if (imem.im_addr !== 32'h40) begin fails++; $display("FAIL redir_pre_addr: got %h required 00000040", imem.im_addr); end
      mem_lat = 2; redirect = 1'b1; redirect_pc = 32'h0000_0203;
      step();
      redirect = 1'b0; redirect_pc = 32'd0;
      for (int c = 17; c < 19; c++) begin
         tests_run++;
         if (imem.im_req !== 1'b1 || imem.im_addr !== 32'h40 || isinstruct_IF !== 1'b0 || instr !== NOP) begin
            fails++;
            $display("FAIL redir_kill[%0d]: req %b addr %h valid %b required 1 00000040 0", c, imem.im_req, imem.im_addr, isinstruct_IF);
         end
         step();
      end
      for (int c = 19; c < 22; c++) begin
         tests_run++;
         if (imem.im_addr !== 32'h200 || isinstruct_IF !== 1'b0) begin
            fails++;
            $display("FAIL redir_new[%0d]: addr %h valid %b required 00000200 0", c, imem.im_addr, isinstruct_IF);
         end
         step();
      end
      tests_run++;
      if (instr !== mem_word(32'h200) || pc_out !== 32'h200 || isinstruct_IF !== 1'b1) begin
         fails++;
         $display("FAIL redir_target: instr %h pc %h required %h 00000200", instr, pc_out, mem_word(32'h200));
      end
      mem_lat = 1000; step(); step();
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL redir_drain: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_redirect_stall_ack();
      do_reset(0);
      push_exp(32'h300);
      step();
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0300;
      step();
      redirect = 1'b0; stall = 1'b0;
      tests_run++;
      if (imem.im_addr !== 32'h300 || isinstruct_IF !== 1'b0 || instr !== NOP || pc_out !== 32'd0 ||
          dut.u_skid.valid_r !== 1'b0 || dut.state_r !== ST_FETCH) begin
         fails++;
         $display("FAIL rsa_flush: addr %h valid %b instr %h skid %b required 00000300 0 %h 0", imem.im_addr, isinstruct_IF, instr, dut.u_skid.valid_r, NOP);
      end
      step();
      tests_run++;
      if (instr !== mem_word(32'h300) || pc_out !== 32'h300 || isinstruct_IF !== 1'b1) begin
         fails++;
         $display("FAIL rsa_target: instr %h pc %h required %h 00000300", instr, pc_out, mem_word(32'h300));
      end
      mem_lat = 1000; step(); step();
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL rsa_drain: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_in_hold();
      do_reset(0);
      push_exp(32'h0);
      stall = 1'b1;
      step();
      tests_run++;
      if (dut.state_r !== ST_HOLD) begin fails++; $display("FAIL rih_hold: state %0d required %0d", dut.state_r, ST_HOLD); end
      rst = 1'b1; mem_lat = 2;
      #1;
      tests_run++;
      if (imem.im_req !== 1'b0) begin fails++; $display("FAIL rih_req_in_rst: got %b required 0", imem.im_req); end
      step();
      rst = 1'b0; stall = 1'b0;
      #1;
      tests_run++;
      if (imem.im_req !== 1'b1 || imem.im_addr !== 32'd0 || dut.u_skid.valid_r !== 1'b0) begin
         fails++;
         $display("FAIL rih_restart: req %b addr %h skid %b required 1 00000000 0", imem.im_req, imem.im_addr, dut.u_skid.valid_r);
      end
      for (int c = 0; c < 3; c++) begin
         tests_run++;
         if (isinstruct_IF !== 1'b0) begin fails++; $display("FAIL rih_bubble[%0d]: got %b required 0", c, isinstruct_IF); end
         step();
      end
      tests_run++;
      if (instr !== mem_word(32'h0) || pc_out !== 32'd0 || isinstruct_IF !== 1'b1) begin
         fails++;
         $display("FAIL rih_first: instr %h valid %b required %h 1", instr, isinstruct_IF, mem_word(32'h0));
      end
      mem_lat = 1000; step(); step();
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL rih_drain: %0d left, required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_latency();
      test_stall();
      test_redirect_pending();
      test_redirect_stall_ack();
      test_reset_in_hold();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
